// File: rtl/pid_pkg.sv
// pid_pkg: shared definitions for the sampled PID controller.
//   pid_state_t   sample sequencer states
//   ACC_GUARD     accumulator guard bits above the widest product
//   acc_width()   accumulator width for a given data/coefficient width
//   sat_signed()  saturate a signed value to a w-bit signed range
//   clamp_window() clamp a signed value into [lo, hi]
// Arithmetic helpers work on 64-bit signed values; callers size-cast the
// result back to their own width, so the accumulator must fit in 64 bits.
package pid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      SENSE,
      MAC0,
      MAC1,
      MAC2,
      OUT
   } pid_state_t;

   localparam int unsigned ACC_GUARD = 3;

   function automatic int unsigned acc_width(input int unsigned w, input int unsigned cw);
      return w + cw + ACC_GUARD;
   endfunction

   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                     input int unsigned      w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) begin
         return hi;
      end
      if (x < lo) begin
         return lo;
      end
      return x;
   endfunction

   function automatic logic signed [63:0] clamp_window(input logic signed [63:0] y,
                                                       input logic signed [63:0] lo,
                                                       input logic signed [63:0] hi);
      if (y > hi) begin
         return hi;
      end
      if (y < lo) begin
         return lo;
      end
      return y;
   endfunction

endpackage

// File: rtl/pid_sample_timer.sv
// pid_sample_timer: sample-period tick generator.
//   clk, rst  clock, asynchronous active-high reset
//   en        count enable; the counter is held at 0 while low
//   restart   forces the counter back to 0 and suppresses tick
//   ts        period minus 1 (counter runs 0..ts)
//   tick      one-cycle pulse when the counter reaches ts; period is ts+1
module pid_sample_timer #(
   parameter int unsigned TSW = 18
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           restart,
   input  logic [TSW-1:0] ts,
   output logic           tick
);

   logic [TSW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!en || restart || count == ts) begin
         count <= '0;
      end else begin
         count <= count + TSW'(1);
      end
   end

   assign tick = en && !restart && (count == ts);

endmodule

// File: rtl/pid_sampled_ctrl.sv
// pid_sampled_ctrl: incremental (velocity-form) PID with programmable
// sample period, sensor start/done handshake and a single shared multiplier.
//   clk, rst            clock, asynchronous active-high reset
//   run                 level, loop active while high
//   ts                  sample period minus 1, in clk cycles
//   set_point, meas     signed target and sensor value (meas valid on eo_sensor)
//   eo_sensor           sensor conversion done pulse
//   b0, b1, b2          signed coefficients, FRAC fractional bits
//   sat_umax, sat_umin  signed output clamp window (umin <= umax)
//   st_sensor           start-conversion pulse
//   ena                 high while the loop is active
//   u_k, sat            registered output and its clamp flag
//   overrun             sticky, a tick arrived while a sample was in flight
//   eop                 one-cycle pulse when u_k updates
// Optional build macro SP_RAMP_EN: rate-limits the set point by RAMP_STEP
// per sample through an internal register sp_r.
module pid_sampled_ctrl
   import pid_pkg::*;
#(
   parameter int unsigned W         = 16,
   parameter int unsigned CW        = 16,
   parameter int unsigned FRAC      = 8,
   parameter int unsigned TSW       = 18,
   parameter int unsigned RAMP_STEP = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [TSW-1:0]       ts,
   input  logic signed [W-1:0]  set_point,
   input  logic signed [W-1:0]  meas,
   input  logic                 eo_sensor,
   input  logic signed [CW-1:0] b0,
   input  logic signed [CW-1:0] b1,
   input  logic signed [CW-1:0] b2,
   input  logic signed [W-1:0]  sat_umax,
   input  logic signed [W-1:0]  sat_umin,
   output logic                 st_sensor,
   output logic                 ena,
   output logic signed [W-1:0]  u_k,
   output logic                 sat,
   output logic                 overrun,
   output logic                 eop
);

   localparam int unsigned ACC_W = acc_width(W, CW);

   pid_state_t state, state_next;

   logic tick;
   logic st_next, ena_next, ovr_set, ovr_clr, do_latch, do_out;

   logic signed [W-1:0]      e, e1, e2, u1;
   logic signed [W-1:0]      sp_eff, err_new, y_clamped;
   logic signed [W:0]        err_diff;
   logic signed [CW-1:0]     mul_coef;
   logic signed [W-1:0]      mul_data;
   logic signed [W+CW-1:0]   prod;
   logic signed [ACC_W-1:0]  acc, acc_fin, prod_ext, u1_scaled, y;
   logic                     sat_hit;

   pid_sample_timer #(
      .TSW (TSW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .en      (ena),
      .restart (state == IDLE),
      .ts      (ts),
      .tick    (tick)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      st_next    = 1'b0;
      ena_next   = ena;
      ovr_set    = 1'b0;
      ovr_clr    = 1'b0;
      do_latch   = 1'b0;
      do_out     = 1'b0;
      case (state)
         IDLE: begin
            if (run) begin
               state_next = WAIT;
               ena_next   = 1'b1;
               ovr_clr    = 1'b1;
            end
         end
         WAIT: begin
            if (!run) begin
               state_next = IDLE;
               ena_next   = 1'b0;
            end else if (tick) begin
               state_next = SENSE;
               st_next    = 1'b1;
            end
         end
         SENSE: begin
            ovr_set = tick;
            if (eo_sensor) begin
               do_latch   = 1'b1;
               state_next = MAC0;
            end
         end
         MAC0: begin
            ovr_set    = tick;
            state_next = MAC1;
         end
         MAC1: begin
            ovr_set    = tick;
            state_next = MAC2;
         end
         MAC2: begin
            // The last product is folded straight into the output registers
            // so the updated u_k and eop are visible during OUT, which keeps
            // eo_sensor-to-eop at four cycles.
            ovr_set    = tick;
            do_out     = 1'b1;
            state_next = OUT;
         end
         OUT: begin
            ovr_set    = tick;
            state_next = WAIT;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------- set point
`ifdef SP_RAMP_EN
   localparam logic signed [W:0]   RSTEP_X = (W+1)'(RAMP_STEP);
   localparam logic signed [W-1:0] RSTEP_W = W'(RAMP_STEP);

   logic signed [W-1:0] sp_r;
   logic signed [W:0]   sp_gap;

   always_comb begin
      sp_gap = (W+1)'(set_point) - (W+1)'(sp_r);
      if (sp_gap > RSTEP_X) begin
         sp_eff = sp_r + RSTEP_W;
      end else if (sp_gap < -RSTEP_X) begin
         sp_eff = sp_r - RSTEP_W;
      end else begin
         sp_eff = set_point;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_r <= '0;
      end else if (do_latch) begin
         sp_r <= sp_eff;
      end
   end
`else
   assign sp_eff = set_point;

   if (RAMP_STEP == 0) begin : g_ramp_step_unused
   end
`endif

   // ------------------------------------------------------------ datapath
   assign err_diff = (W+1)'(sp_eff) - (W+1)'(meas);
   assign err_new  = W'(sat_signed(64'(err_diff), W));

   always_comb begin
      mul_coef = b2;
      mul_data = e2;
      case (state)
         MAC0: begin
            mul_coef = b0;
            mul_data = e;
         end
         MAC1: begin
            mul_coef = b1;
            mul_data = e1;
         end
         default: ;
      endcase
   end

   assign prod      = (W+CW)'(mul_coef) * (W+CW)'(mul_data);
   assign prod_ext  = ACC_W'(prod);
   assign u1_scaled = ACC_W'(u1) <<< FRAC;
   assign acc_fin   = acc + prod_ext;
   assign y         = acc_fin >>> FRAC;
   assign y_clamped = W'(clamp_window(64'(y), 64'(sat_umin), 64'(sat_umax)));
   assign sat_hit   = (ACC_W'(y_clamped) != y);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ena       <= 1'b0;
         st_sensor <= 1'b0;
         eop       <= 1'b0;
         overrun   <= 1'b0;
         u_k       <= '0;
         sat       <= 1'b0;
         e         <= '0;
         e1        <= '0;
         e2        <= '0;
         u1        <= '0;
         acc       <= '0;
      end else begin
         ena       <= ena_next;
         st_sensor <= st_next;
         eop       <= do_out;
         if (ovr_clr) begin
            overrun <= 1'b0;
         end else if (ovr_set) begin
            overrun <= 1'b1;
         end
         if (do_latch) begin
            e <= err_new;
         end
         if (state == MAC0) begin
            acc <= u1_scaled + prod_ext;
         end else if (state == MAC1) begin
            acc <= acc_fin;
         end
         // u1 keeps the clamped value, so the integrator cannot wind up.
         if (do_out) begin
            u_k <= y_clamped;
            sat <= sat_hit;
            u1  <= y_clamped;
            e2  <= e1;
            e1  <= e;
         end
      end
   end

endmodule

// File: doc/pid_sampled_ctrl.md
Name: pid_sampled_ctrl

Overview:
Parametrised successor of the sampled PD loop. It is a discrete PID controller in incremental (velocity) form with a programmable sample period and a sensor start/done handshake. It computes u[k] with one shared multiplier over several cycles and clamps the result to a runtime window. It sits between the sensor-acquisition block and the actuator/PWM stage.

Parameters:
W, 16, signed width of setpoint, measurement, error and u_k
CW, 16, signed coefficient width
FRAC, 8, fractional bits of the coefficients (the product is shifted right arithmetically by FRAC)
TSW, 18, width of the sample-period register
RAMP_STEP, 4, maximum setpoint change per sample (used only with SP_RAMP_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
run  in  1  level; high = loop active
ts  in  TSW  sample period minus 1, in clk cycles
set_point  in  W  signed target
meas  in  W  signed sensor value; valid when eo_sensor=1
eo_sensor  in  1  sensor conversion done, 1-cycle pulse
b0, b1, b2  in  CW  signed incremental-PID coefficients
sat_umax, sat_umin  in  W  signed clamp window; umin<=umax is required
st_sensor  out  1  start-conversion pulse
ena  out  1  high while the loop is active
u_k  out  W  signed registered control output
sat  out  1  last u_k was clamped
overrun  out  1  sticky; a tick arrived before the sample completed
eop  out  1  1-cycle pulse when u_k updates

Behaviour:
- Reset: all outputs 0; e1, e2 and u1 history registers 0; FSM in IDLE; timer 0.
- Timer: runs only while ena=1. It counts 0..ts, then raises tick for one cycle and wraps to 0. The period is exactly ts+1 cycles. The timer restarts from 0 when entering RUN from IDLE.
- FSM:
  - IDLE: waits for run=1, then sets ena=1 and goes to WAIT.
  - WAIT: on tick, drives st_sensor=1 for one cycle and goes to SENSE.
  - SENSE: waits for eo_sensor. If eo_sensor and st_sensor coincide, the pulse is accepted. On eo_sensor, latches e = sat_W(sp - meas) with a saturating subtraction, then goes to MAC0.
  - MAC0, MAC1, MAC2: one multiply per cycle into an accumulator of width W+CW+3.
    - MAC0: acc = (u1 <<< FRAC) + b0*e
    - MAC1: acc += b1*e1
    - MAC2: acc += b2*e2
  - OUT: y = acc >>> FRAC, clamped to [umin, umax]. Registers u_k=y, sat=(y was clamped), u1=y, e2=e1, e1=e, and pulses eop. Then goes to WAIT.
- Latency: eo_sensor to eop is exactly 4 cycles.
- Anti-windup: u1 stores the clamped value, so no integrator windup occurs.
- Overrun: a tick seen in SENSE, MAC* or OUT sets overrun. That tick is dropped, and no second st_sensor is issued. overrun clears only on reset or on an IDLE->WAIT transition.
- Stop: run=0 is honoured only in WAIT, going to IDLE with ena=0. An in-flight sample always completes. History registers are kept across stop/start.
- Coefficient and clamp inputs are sampled in MAC*/OUT and may change between samples.
- Reset mid-sample: all state clears immediately. No eop is issued for the aborted sample.

Optional Feature:
SP_RAMP_EN
- Defined: an internal register sp_r (reset 0) replaces set_point in the error calculation. On each eo_sensor, sp_r moves toward set_point by at most RAMP_STEP, landing exactly on set_point when within the step.
- Undefined: set_point is used directly, and sp_r and its logic are absent.

Decomposition:
- Package pid_pkg: FSM state enum (IDLE, WAIT, SENSE, MAC0, MAC1, MAC2, OUT), accumulator-width localparam, and saturate/clamp functions.
- One sub-module, pid_sample_timer: tick generator with TSW parameter, enable and restart inputs.

Test Plan:
- Integrator: FRAC=8, b0=256, b1=b2=0, sp=10, meas=0, ts=9, window ±1000. Expect u_k=10,20,30 on successive eops, eops 10 cycles apart, and eop 4 cycles after eo_sensor.
- Proportional: b0=256, b1=-256, b2=0, sp=50, meas stepping 0,20,20. Expect u_k=50,30,30.
- Saturation/anti-windup: integrator setup with umax=25, sp=10. Expect u_k=10,20,25,25 with sat=1 from the third sample. Then sp=-10: expect u_k=15 immediately (no windup).
- Overrun: ts=2 and sensor responds after 5 cycles. Expect overrun=1 with no extra st_sensor; stop then run clears it.
- Stop/reset: run=0 during MAC1 gives eop, then ena=0 in the next WAIT. rst asserted in SENSE clears all outputs in the same cycle.
- SP_RAMP_EN with RAMP_STEP=4, set_point 0→10, meas=0, b0=256, b1=-256. Expect u_k=4,8,10.
